// File: rtl/rggen_adapter_common_timeout.sv
// Shared rggen bus-to-register adapter core: decode, localise, optional slicing and response mux,
// plus a per-access response watchdog and a saturating timeout event counter.
module rggen_adapter_common_timeout #(
  parameter int                    ADDRESS_WIDTH       = 8,
  parameter int                    LOCAL_ADDRESS_WIDTH = 8,
  parameter int                    BUS_WIDTH           = 32,
  parameter int                    STROBE_WIDTH        = BUS_WIDTH / 8,
  parameter int                    REGISTERS           = 1,
  parameter int                    PRE_DECODE          = 0,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS       = '0,
  parameter int                    BYTE_SIZE           = 256,
  parameter int                    USE_READ_STROBE     = 0,
  parameter int                    ERROR_STATUS        = 0,
  parameter bit [BUS_WIDTH-1:0]    DEFAULT_READ_DATA   = '0,
  parameter int                    INSERT_SLICER       = 0,
  parameter int                    TIMEOUT_CYCLES      = 0,
  parameter bit [1:0]              TIMEOUT_STATUS      = 2'b10,
  parameter int                    COUNT_WIDTH         = 8
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_bus_valid,
  input  logic [1:0]                     i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
  input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
  input  logic [STROBE_WIDTH-1:0]        i_bus_strobe,
  output logic                           o_bus_ready,
  output logic [1:0]                     o_bus_status,
  output logic [BUS_WIDTH-1:0]           o_bus_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data,
  output logic                           o_timeout,
  output logic [COUNT_WIDTH-1:0]         o_timeout_count
);

  localparam logic [1:0] RGGEN_READ     = 2'b10;
  localparam logic [1:0] DEFAULT_STATUS = (ERROR_STATUS != 0) ? 2'b10 : 2'b00;
  localparam int         AW1            = ADDRESS_WIDTH + 1;
  localparam int         WD_WIDTH       = $clog2(TIMEOUT_CYCLES + 2) + 1;
  localparam logic [AW1-1:0]                 SIZE_W     = AW1'(BYTE_SIZE);
  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] BASE_LOCAL = LOCAL_ADDRESS_WIDTH'(BASE_ADDRESS);
  localparam logic [WD_WIDTH-1:0]            WD_LIMIT   = WD_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_e;

  state_e                        state_r;
  logic [WD_WIDTH-1:0]           wd_r;
  logic [COUNT_WIDTH-1:0]        cnt_r;
  logic [AW1-1:0]                offset_s;
  logic                          inside_range_s;
  logic [BUS_WIDTH-1:0]          strobe_bits_s;
  logic [BUS_WIDTH-1:0]          req_strobe_s;
  logic [LOCAL_ADDRESS_WIDTH-1:0] req_address_s;
  logic                          ready_hit_s;
  logic [1:0]                    mux_status_s;
  logic [BUS_WIDTH-1:0]          mux_data_s;
  logic                          inactive_s;
  logic                          bus_cycle_s;
  logic [WD_WIDTH-1:0]           elapsed_s;
  logic                          timeout_hit_s;
  logic                          bus_done_s;

  // Range check: the offset must not borrow and must fall below the block size.
  always_comb begin
    offset_s = {1'b0, i_bus_address} - {1'b0, BASE_ADDRESS};
    if (PRE_DECODE != 0) begin
      inside_range_s = !offset_s[ADDRESS_WIDTH] && ({1'b0, offset_s[ADDRESS_WIDTH-1:0]} < SIZE_W);
    end else begin
      inside_range_s = 1'b1;
    end
  end

  if (STROBE_WIDTH == BUS_WIDTH) begin : g_strobe_pass
    assign strobe_bits_s = i_bus_strobe;
  end else begin : g_strobe_expand
    for (genvar i = 0; i < STROBE_WIDTH; i++) begin : g_byte
      assign strobe_bits_s[8*i+:8] = {8{i_bus_strobe[i]}};
    end
  end

  // Modular subtraction of the base's low bits equals plain truncation when those bits are zero.
  assign req_address_s = LOCAL_ADDRESS_WIDTH'(i_bus_address) - BASE_LOCAL;
  assign req_strobe_s  = ((i_bus_access == RGGEN_READ) && (USE_READ_STROBE == 0)) ? '1 : strobe_bits_s;

  // One-hot response mux gated by each register's address hit.
  always_comb begin
    ready_hit_s  = 1'b0;
    mux_status_s = 2'b00;
    mux_data_s   = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      ready_hit_s  = ready_hit_s | (i_register_active[i] & i_register_ready[i]);
      mux_status_s = mux_status_s | ({2{i_register_active[i]}} & i_register_status[2*i+:2]);
      mux_data_s   = mux_data_s | ({BUS_WIDTH{i_register_active[i]}} & i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH]);
    end
  end

  // With the slicer the registers only see the request from ISSUE on, so IDLE never completes.
  assign inactive_s    = (i_register_active == '0) || !inside_range_s;
  assign bus_cycle_s   = !i_rst && i_bus_valid && ((state_r != IDLE) || (INSERT_SLICER == 0));
  assign elapsed_s     = (state_r == IDLE) ? WD_WIDTH'(1) : (wd_r + WD_WIDTH'(1));
  assign timeout_hit_s = (TIMEOUT_CYCLES > 0) && bus_cycle_s && !inactive_s && !ready_hit_s
                         && (elapsed_s >= WD_LIMIT);
  assign bus_done_s    = bus_cycle_s && (inactive_s || ready_hit_s || timeout_hit_s);

  // Response selection: a real register response outranks the watchdog.
  always_comb begin
    if (timeout_hit_s) begin
      o_bus_status    = TIMEOUT_STATUS;
      o_bus_read_data = DEFAULT_READ_DATA;
    end else if (inactive_s) begin
      o_bus_status    = DEFAULT_STATUS;
      o_bus_read_data = DEFAULT_READ_DATA;
    end else begin
      o_bus_status    = mux_status_s;
      o_bus_read_data = mux_data_s;
    end
  end

  assign o_bus_ready     = bus_done_s;
  assign o_timeout       = timeout_hit_s;
  assign o_timeout_count = cnt_r;

  // Access FSM and watchdog cycle counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      wd_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_bus_valid && !bus_done_s) begin
            state_r <= (INSERT_SLICER != 0) ? ISSUE : WAIT;
            wd_r    <= WD_WIDTH'(1);
          end else begin
            state_r <= IDLE;
            wd_r    <= '0;
          end
        end
        ISSUE, WAIT: begin
          if (bus_done_s) begin
            state_r <= IDLE;
            wd_r    <= '0;
          end else begin
            state_r <= WAIT;
            wd_r    <= (wd_r != '1) ? (wd_r + WD_WIDTH'(1)) : wd_r;
          end
        end
        default: begin
          state_r <= IDLE;
          wd_r    <= '0;
        end
      endcase
    end
  end

  // Saturating timeout event counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= '0;
    end else if (timeout_hit_s && (cnt_r != '1)) begin
      cnt_r <= cnt_r + COUNT_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  if (INSERT_SLICER != 0) begin : g_slicer
    logic                           slice_valid_r;
    logic [1:0]                     slice_access_r;
    logic [LOCAL_ADDRESS_WIDTH-1:0] slice_address_r;
    logic [BUS_WIDTH-1:0]           slice_write_data_r;
    logic [BUS_WIDTH-1:0]           slice_strobe_r;

    // Capture the request at acceptance; the pulse is only raised for in-range accesses.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        slice_valid_r      <= 1'b0;
        slice_access_r     <= 2'b00;
        slice_address_r    <= '0;
        slice_write_data_r <= '0;
        slice_strobe_r     <= '0;
      end else if ((state_r == IDLE) && i_bus_valid) begin
        slice_valid_r      <= inside_range_s;
        slice_access_r     <= i_bus_access;
        slice_address_r    <= req_address_s;
        slice_write_data_r <= i_bus_write_data;
        slice_strobe_r     <= req_strobe_s;
      end else begin
        slice_valid_r      <= 1'b0;
      end
    end

    assign o_register_valid      = (state_r == ISSUE) && slice_valid_r;
    assign o_register_access     = slice_access_r;
    assign o_register_address    = slice_address_r;
    assign o_register_write_data = slice_write_data_r;
    assign o_register_strobe     = slice_strobe_r;
  end else begin : g_direct
    assign o_register_valid      = !i_rst && (state_r == IDLE) && i_bus_valid && inside_range_s;
    assign o_register_access     = i_bus_access;
    assign o_register_address    = req_address_s;
    assign o_register_write_data = i_bus_write_data;
    assign o_register_strobe     = req_strobe_s;
  end

endmodule

// File: tb/tb_rggen_adapter_common_timeout.sv
// Bench for rggen_adapter_common_timeout: a direct instance and a sliced instance, checked every
// cycle against a per-transaction completion model, plus literal expectations for key scenarios.
module tb_rggen_adapter_common_timeout;

  localparam int          T        = 4;
  localparam logic [1:0]  RD       = 2'b10;
  localparam logic [1:0]  WR       = 2'b01;
  localparam logic [31:0] DEF_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel         = 0;
  logic        bus_valid   = 1'b0;
  logic [1:0]  bus_access  = RD;
  logic [15:0] bus_address = 16'h0000;
  logic [31:0] bus_wdata   = 32'h0;
  logic [3:0]  bus_strobe  = 4'h0;
  logic [1:0]  reg_active  = 2'b00;
  logic [1:0]  reg_ready   = 2'b00;
  logic [3:0]  reg_status  = 4'h0;
  logic [63:0] reg_rdata   = 64'h0;

  logic        rdy_o  [2];
  logic [1:0]  st_o   [2];
  logic [31:0] rd_o   [2];
  logic        regv_o [2];
  logic [1:0]  racc_o [2];
  logic [7:0]  radr_o [2];
  logic [31:0] rwd_o  [2];
  logic [31:0] rstb_o [2];
  logic        to_o   [2];
  logic [7:0]  cnt_o  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rggen_adapter_common_timeout #(
      .ADDRESS_WIDTH(16), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4),
      .REGISTERS(2), .PRE_DECODE(1), .BASE_ADDRESS((g == 0) ? 16'h0100 : 16'h0120),
      .BYTE_SIZE(64), .USE_READ_STROBE(0), .ERROR_STATUS(1), .DEFAULT_READ_DATA(DEF_DATA),
      .INSERT_SLICER(g), .TIMEOUT_CYCLES(T), .TIMEOUT_STATUS(2'b10), .COUNT_WIDTH(8)
    ) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_bus_valid(bus_valid && (sel == g)), .i_bus_access(bus_access),
      .i_bus_address(bus_address), .i_bus_write_data(bus_wdata), .i_bus_strobe(bus_strobe),
      .o_bus_ready(rdy_o[g]), .o_bus_status(st_o[g]), .o_bus_read_data(rd_o[g]),
      .o_register_valid(regv_o[g]), .o_register_access(racc_o[g]),
      .o_register_address(radr_o[g]), .o_register_write_data(rwd_o[g]),
      .o_register_strobe(rstb_o[g]),
      .i_register_active(reg_active), .i_register_ready(reg_ready),
      .i_register_status(reg_status), .i_register_read_data(reg_rdata),
      .o_timeout(to_o[g]), .o_timeout_count(cnt_o[g])
    );
  end

  // Model of the transaction in flight, expressed as cycle numbers counted from acceptance.
  bit          chk_en = 1'b0;
  bit          busy   = 1'b0;
  int          k      = 0;
  int          exp_done, exp_issue;
  bit          exp_to, exp_regv;
  logic [1:0]  exp_status, exp_acc;
  logic [31:0] exp_data, exp_wdata, exp_strobe;
  logic [7:0]  exp_addr;
  int          cnt_m [2];

  int          last_done, last_regv_k;
  logic [1:0]  last_status;
  logic [31:0] last_data, last_strobe;
  logic [7:0]  last_addr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_ready", 64'(rdy_o[sel]), 64'(busy && (k == exp_done)));
      check("timeout_pulse", 64'(to_o[sel]), 64'(busy && (k == exp_done) && exp_to));
      check("register_valid", 64'(regv_o[sel]), 64'(busy && (k == exp_issue) && exp_regv));
      check("timeout_count", 64'(cnt_o[sel]), 64'(cnt_m[sel]));
      if (busy && (k == exp_done)) begin
        check("bus_status", 64'(st_o[sel]), 64'(exp_status));
        check("bus_read_data", 64'(rd_o[sel]), 64'(exp_data));
      end
      if (busy && (k == exp_issue) && exp_regv) begin
        check("register_access", 64'(racc_o[sel]), 64'(exp_acc));
        check("register_address", 64'(radr_o[sel]), 64'(exp_addr));
        check("register_write_data", 64'(rwd_o[sel]), 64'(exp_wdata));
        check("register_strobe", 64'(rstb_o[sel]), 64'(exp_strobe));
      end
    end
  end

  // r: cycle in which the addressed register raises ready (0 or > T = never).
  // abort_at: cycle in which reset is pulsed instead of letting the access finish (0 = none).
  task automatic run_txn(input int d, input logic [15:0] addr, input logic [1:0] acc,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [1:0] act, input int r, input int abort_at);
    logic [15:0] base;
    bit          in_range;
    int          f, idx;
    logic [1:0]  noise;
    base     = (d == 0) ? 16'h0100 : 16'h0120;
    in_range = (addr >= base) && (addr < base + 16'd64);
    f        = (d == 0) ? 1 : 2;
    idx      = act[1] ? 1 : 0;
    exp_issue = f;
    exp_regv  = in_range;
    exp_addr  = 8'(addr - base);
    exp_acc   = acc;
    exp_wdata = wdata;
    for (int b = 0; b < 4; b++) exp_strobe[8*b+:8] = (acc == RD) ? 8'hFF : {8{strb[b]}};
    if (!in_range || (act == 2'b00)) begin
      exp_done = f; exp_status = 2'b10; exp_data = DEF_DATA; exp_to = 1'b0;
    end else if ((r >= f) && (r <= T)) begin
      exp_done = r; exp_status = reg_status[2*idx+:2]; exp_data = reg_rdata[32*idx+:32]; exp_to = 1'b0;
    end else begin
      exp_done = T; exp_status = 2'b10; exp_data = DEF_DATA; exp_to = 1'b1;
    end
    sel = d; bus_valid = 1'b1; bus_address = addr; bus_access = acc;
    bus_wdata = wdata; bus_strobe = strb; reg_active = act; busy = 1'b1;
    last_done = 0; last_regv_k = 0;
    for (int kk = 1; kk <= exp_done; kk++) begin
      k = kk;
      noise = 2'($urandom);
      reg_ready = ((kk == r) ? act : 2'b00) | (noise & ~act);
      if (kk == abort_at) begin
        rst = 1'b1; busy = 1'b0; cnt_m[0] = 0; cnt_m[1] = 0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; bus_valid = 1'b0; reg_ready = 2'b00; k = 0;
        return;
      end
      @(negedge clk);
      if (rdy_o[d] && (last_done == 0)) begin
        last_done = kk; last_status = st_o[d]; last_data = rd_o[d];
      end
      if (regv_o[d] && (last_regv_k == 0)) begin
        last_regv_k = kk; last_addr = radr_o[d]; last_strobe = rstb_o[d];
      end
      @(posedge clk); #1;
    end
    if (exp_to && (cnt_m[d] < 255)) cnt_m[d]++;
    busy = 1'b0; k = 0; bus_valid = 1'b0; reg_ready = 2'b00;
  endtask

  // Idle cycles with register-side noise, including stray ready pulses that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      reg_active = 2'($urandom);
      reg_ready  = 2'($urandom);
      @(negedge clk);
      @(posedge clk); #1;
    end
    reg_ready = 2'b00;
  endtask

  initial begin
    int          d, x, r;
    logic [15:0] base, addr;
    logic [1:0]  act;
    cnt_m[0] = 0; cnt_m[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_count", 64'(cnt_o[0]), 64'd0);
    check("reset_ready", 64'(rdy_o[0]), 64'd0);
    check("reset_timeout", 64'(to_o[1]), 64'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read from register 1.
    reg_status = 4'b01_11;
    reg_rdata  = {32'h0000_ABCD, 32'h1111_2222};
    run_txn(0, 16'h0104, RD, 32'h0, 4'hF, 2'b10, 1, 0);
    check("zw_done_cycle", 64'(last_done), 64'd1);
    check("zw_read_data", 64'(last_data), 64'h0000_ABCD);
    check("zw_status", 64'(last_status), 64'(2'b01));
    idle(1);

    // Sliced write: request pulse and earliest completion both in cycle 2.
    run_txn(1, 16'h0134, WR, 32'h1234_5678, 4'b0011, 2'b01, 2, 0);
    check("slice_valid_cycle", 64'(last_regv_k), 64'd2);
    check("slice_strobe", 64'(last_strobe), 64'h0000_FFFF);
    check("slice_address", 64'(last_addr), 64'h14);
    check("slice_done_cycle", 64'(last_done), 64'd2);

    // Out-of-range access completes immediately with the error status.
    run_txn(0, 16'h0140, RD, 32'h0, 4'hF, 2'b01, 1, 0);
    check("oor_done_cycle", 64'(last_done), 64'd1);
    check("oor_status", 64'(last_status), 64'(2'b10));
    check("oor_data", 64'(last_data), 64'(DEF_DATA));
    check("oor_no_reg_valid", 64'(last_regv_k), 64'd0);

    // Watchdog expiry, then a response arriving exactly in the expiry cycle.
    run_txn(0, 16'h0108, RD, 32'h0, 4'hF, 2'b01, 0, 0);
    check("to_done_cycle", 64'(last_done), 64'd4);
    check("to_status", 64'(last_status), 64'(2'b10));
    check("to_count_1", 64'(cnt_o[0]), 64'd1);
    run_txn(0, 16'h0108, RD, 32'h0, 4'hF, 2'b01, 4, 0);
    check("late_ok_done_cycle", 64'(last_done), 64'd4);
    check("late_ok_status", 64'(last_status), 64'(2'b11));
    check("late_ok_data", 64'(last_data), 64'h1111_2222);
    check("late_ok_count", 64'(cnt_o[0]), 64'd1);
    idle(2);

    // Randomized traffic on both instances, with and without gaps.
    for (int n = 0; n < 250; n++) begin
      d    = int'($urandom_range(0, 1));
      base = (d == 0) ? 16'h0100 : 16'h0120;
      addr = base - 16'd16 + 16'($urandom_range(0, 95));
      x    = int'($urandom_range(0, 2));
      act  = (x == 0) ? 2'b00 : ((x == 1) ? 2'b01 : 2'b10);
      r    = int'($urandom_range(0, 6));
      reg_status = 4'($urandom);
      reg_rdata  = {$urandom, $urandom};
      run_txn(d, addr, ($urandom_range(0, 1) == 0) ? RD : WR, $urandom, 4'($urandom), act, r, 0);
      idle(int'($urandom_range(0, 2)));
    end

    // Counter saturation.
    for (int n = 0; n < 300; n++) run_txn(0, 16'h0110, RD, 32'h0, 4'hF, 2'b01, 0, 0);
    check("count_saturated", 64'(cnt_o[0]), 64'd255);

    // Reset during the second cycle of an access, then a fresh timed-out access.
    run_txn(0, 16'h0108, RD, 32'h0, 4'hF, 2'b01, 0, 2);
    check("abort_count_cleared", 64'(cnt_o[0]), 64'd0);
    idle(1);
    run_txn(0, 16'h010C, RD, 32'h0, 4'hF, 2'b01, 0, 0);
    check("post_reset_done_cycle", 64'(last_done), 64'd4);
    check("post_reset_count", 64'(cnt_o[0]), 64'd1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
